// File: rtl/sideband_align_fifo_pkg.sv
// Shared definitions for the sideband alignment FIFO: sideband word size,
// state encoding and the sideband vector width helper.
package sideband_align_fifo_pkg;

   localparam int SB_WORD_WIDTH = 32;

   typedef enum logic {
      ST_SOP  = 1'b0,
      ST_BODY = 1'b1
   } state_e;

   function automatic int sb_vec_width(input int num_words);
      return num_words * SB_WORD_WIDTH;
   endfunction

endpackage

// File: rtl/sideband_align_fifo_fifo.sv
// Generic fall-through FIFO: the head entry is presented on o_rd_data whenever
// o_empty is low, so a word written at one edge is readable right after it.
module sideband_align_fifo_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [WIDTH-1:0]      i_wr_data,
   input  logic                  i_rd_en,
   output logic [WIDTH-1:0]      o_rd_data,
   output logic                  o_empty,
   output logic [DEPTH_BITS:0]   o_count
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] PTR_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
   localparam logic [DEPTH_BITS:0] CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [DEPTH_BITS:0] r_wr_ptr;
   logic [DEPTH_BITS:0] r_rd_ptr;
   logic                w_full;
   logic                w_rd_ok;
   logic                w_wr_ok;

   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_empty   = (o_count == {(DEPTH_BITS + 1){1'b0}});
   assign w_full    = (o_count == CNT_FULL);
   assign w_rd_ok   = i_rd_en & ~o_empty;
   // A write into a full FIFO is taken only when the head leaves in the same cycle
   assign w_wr_ok   = i_wr_en & (~w_full | w_rd_ok);
   assign o_rd_data = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

   // Read/write pointer update
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= {(DEPTH_BITS + 1){1'b0}};
         r_rd_ptr <= {(DEPTH_BITS + 1){1'b0}};
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage write; contents are only observed while non-empty, so no reset
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= i_wr_data;
      end
   end

endmodule

// File: rtl/sideband_align_fifo.sv
// Buffers an AXI4-Stream packet path and releases one queued sideband entry
// per packet, aligned to that packet's first output beat.
module sideband_align_fifo
   import sideband_align_fifo_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_WORDS          = 2,
   parameter int DATA_DEPTH_BITS    = 3,
   parameter int META_DEPTH_BITS    = 2,
   parameter int CLEAR_ON_EOP       = 0
) (
   input  logic                                 AXI_ACLK,
   input  logic                                 AXI_RESETN,
   input  logic [C_AXIS_DATA_WIDTH-1:0]         S_AXIS_TDATA,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]       S_AXIS_TSTRB,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]        S_AXIS_TUSER,
   input  logic                                 S_AXIS_TVALID,
   input  logic                                 S_AXIS_TLAST,
   output logic                                 S_AXIS_TREADY,
   output logic [C_AXIS_DATA_WIDTH-1:0]         M_AXIS_TDATA,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
   output logic [C_AXIS_TUSER_WIDTH-1:0]        M_AXIS_TUSER,
   output logic                                 M_AXIS_TVALID,
   output logic                                 M_AXIS_TLAST,
   input  logic                                 M_AXIS_TREADY,
   input  logic [sb_vec_width(NUM_WORDS)-1:0]   SB_IN,
   input  logic                                 SB_IN_VALID,
   output logic [sb_vec_width(NUM_WORDS)-1:0]   SB_OUT,
   output logic                                 SB_OUT_VALID,
   output logic [15:0]                          SB_DROP_CNT,
   output logic [31:0]                          PKT_CNT
);

   localparam int STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;
   localparam int BEAT_WIDTH = C_AXIS_DATA_WIDTH + C_AXIS_TUSER_WIDTH + STRB_WIDTH + 1;
   localparam int SB_WIDTH   = sb_vec_width(NUM_WORDS);
   localparam int USER_LO    = C_AXIS_DATA_WIDTH + STRB_WIDTH;
   localparam logic [DATA_DEPTH_BITS:0] DATA_NEARLY_FULL =
      (DATA_DEPTH_BITS + 1)'((1 << DATA_DEPTH_BITS) - 1);
   localparam logic [META_DEPTH_BITS:0] META_FULL =
      (META_DEPTH_BITS + 1)'(1 << META_DEPTH_BITS);

   state_e                   r_state;
   logic                     r_run;
   logic [SB_WIDTH-1:0]      r_sb_out;
   logic                     r_sb_out_valid;
   logic [15:0]              r_drop_cnt;
   logic [31:0]              r_pkt_cnt;

   logic [BEAT_WIDTH-1:0]    w_beat_in;
   logic [BEAT_WIDTH-1:0]    w_beat_out;
   logic                     w_data_wr;
   logic                     w_data_empty;
   logic [DATA_DEPTH_BITS:0] w_data_count;
   logic [SB_WIDTH-1:0]      w_meta_out;
   logic                     w_meta_empty;
   logic [META_DEPTH_BITS:0] w_meta_count;
   logic                     w_meta_pop;
   logic                     w_drop;
   logic                     w_tvalid;
   logic                     w_hs;
   logic                     w_last;

   assign w_beat_in     = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
   // r_run keeps upstream ready low while reset is held and for one edge after
   assign S_AXIS_TREADY = r_run & (w_data_count < DATA_NEARLY_FULL);
   assign w_data_wr     = S_AXIS_TVALID & S_AXIS_TREADY;

   assign M_AXIS_TDATA  = w_beat_out[C_AXIS_DATA_WIDTH-1:0];
   assign M_AXIS_TSTRB  = w_beat_out[USER_LO-1:C_AXIS_DATA_WIDTH];
   assign M_AXIS_TUSER  = w_beat_out[BEAT_WIDTH-2:USER_LO];
   assign w_last        = w_beat_out[BEAT_WIDTH-1];
   assign M_AXIS_TLAST  = w_last;
   assign M_AXIS_TVALID = w_tvalid;

   assign w_hs       = w_tvalid & M_AXIS_TREADY;
   assign w_meta_pop = w_hs & (r_state == ST_SOP);
   assign w_drop     = SB_IN_VALID & (w_meta_count == META_FULL) & ~w_meta_pop;

   assign SB_OUT       = r_sb_out;
   assign SB_OUT_VALID = r_sb_out_valid;
   assign SB_DROP_CNT  = r_drop_cnt;
   assign PKT_CNT      = r_pkt_cnt;

   // Output valid: a packet may only start once its sideband entry is queued
   always_comb begin
      w_tvalid = 1'b0;
      if (!r_run || w_data_empty) begin
         w_tvalid = 1'b0;
      end else if (r_state == ST_BODY) begin
         w_tvalid = 1'b1;
      end else begin
         w_tvalid = ~w_meta_empty;
      end
   end

   sideband_align_fifo_fifo #(
      .WIDTH      (BEAT_WIDTH),
      .DEPTH_BITS (DATA_DEPTH_BITS)
   ) u_data_fifo (
      .i_clk      (AXI_ACLK),
      .i_rst_n    (AXI_RESETN),
      .i_wr_en    (w_data_wr),
      .i_wr_data  (w_beat_in),
      .i_rd_en    (w_hs),
      .o_rd_data  (w_beat_out),
      .o_empty    (w_data_empty),
      .o_count    (w_data_count)
   );

   sideband_align_fifo_fifo #(
      .WIDTH      (SB_WIDTH),
      .DEPTH_BITS (META_DEPTH_BITS)
   ) u_meta_fifo (
      .i_clk      (AXI_ACLK),
      .i_rst_n    (AXI_RESETN),
      .i_wr_en    (SB_IN_VALID),
      .i_wr_data  (SB_IN),
      .i_rd_en    (w_meta_pop),
      .o_rd_data  (w_meta_out),
      .o_empty    (w_meta_empty),
      .o_count    (w_meta_count)
   );

   // Packet state machine with registered sideband outputs
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         r_state        <= ST_SOP;
         r_run          <= 1'b0;
         r_sb_out       <= {SB_WIDTH{1'b0}};
         r_sb_out_valid <= 1'b0;
      end else begin
         r_run          <= 1'b1;
         r_sb_out_valid <= 1'b0;
         case (r_state)
            ST_SOP: begin
               if (w_hs) begin
                  r_sb_out       <= w_meta_out;
                  r_sb_out_valid <= 1'b1;
                  r_state        <= w_last ? ST_SOP : ST_BODY;
               end else begin
                  r_state <= ST_SOP;
               end
            end
            ST_BODY: begin
               if (w_hs && w_last) begin
                  r_state <= ST_SOP;
                  if (CLEAR_ON_EOP != 0) begin
                     r_sb_out <= {SB_WIDTH{1'b0}};
                  end
               end else begin
                  r_state <= ST_BODY;
               end
            end
            default: begin
               r_state <= ST_SOP;
            end
         endcase
      end
   end

   // Completed-packet and dropped-sideband counters
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         r_pkt_cnt  <= 32'd0;
         r_drop_cnt <= 16'd0;
      end else begin
         if (w_hs && w_last) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end
         if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sideband_align_fifo.sv
// Scoreboard bench: stimulus queues expected beats and sideband entries, a
// negedge monitor pops and compares whenever the DUT hands over a beat.
module tb_sideband_align_fifo;

   localparam int DW  = 256;
   localparam int UW  = 128;
   localparam int SW  = DW / 8;
   localparam int SBW = 64;

   typedef logic [DW+UW+SW:0] beat_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [DW-1:0]  s_tdata;
   logic [SW-1:0]  s_tstrb;
   logic [UW-1:0]  s_tuser;
   logic           s_tvalid;
   logic           s_tlast;
   logic           s_tready, c_tready;
   logic [DW-1:0]  m_tdata, c_tdata;
   logic [SW-1:0]  m_tstrb, c_tstrb;
   logic [UW-1:0]  m_tuser, c_tuser;
   logic           m_tvalid, c_tvalid;
   logic           m_tlast, c_tlast;
   logic           m_tready;
   logic [SBW-1:0] sb_in;
   logic           sb_in_valid;
   logic [SBW-1:0] sb_out, c_sb_out;
   logic           sb_out_valid, c_sb_out_valid;
   logic [15:0]    sb_drop, c_sb_drop;
   logic [31:0]    pkt_cnt, c_pkt_cnt;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;

   beat_t          exp_beats[$];
   logic [SBW-1:0] exp_sb[$];

   bit             m_sop = 1'b1;
   bit             m_sbv = 1'b0;
   logic [SBW-1:0] m_sb  = '0;
   logic [SBW-1:0] m_clr = '0;
   logic [31:0]    m_pkt = '0;
   beat_t          mon_eb;
   logic [SBW-1:0] mon_sb;

   always #5 clk = ~clk;

   sideband_align_fifo #(.CLEAR_ON_EOP(0)) u_dut (
      .AXI_ACLK(clk), .AXI_RESETN(rst_n),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
      .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
      .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
      .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
      .SB_IN(sb_in), .SB_IN_VALID(sb_in_valid), .SB_OUT(sb_out),
      .SB_OUT_VALID(sb_out_valid), .SB_DROP_CNT(sb_drop), .PKT_CNT(pkt_cnt)
   );

   sideband_align_fifo #(.CLEAR_ON_EOP(1)) u_clr (
      .AXI_ACLK(clk), .AXI_RESETN(rst_n),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
      .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(c_tready),
      .M_AXIS_TDATA(c_tdata), .M_AXIS_TSTRB(c_tstrb), .M_AXIS_TUSER(c_tuser),
      .M_AXIS_TVALID(c_tvalid), .M_AXIS_TLAST(c_tlast), .M_AXIS_TREADY(m_tready),
      .SB_IN(sb_in), .SB_IN_VALID(sb_in_valid), .SB_OUT(c_sb_out),
      .SB_OUT_VALID(c_sb_out_valid), .SB_DROP_CNT(c_sb_drop), .PKT_CNT(c_pkt_cnt)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic beat_t mk_beat(input int id, input bit last);
      logic [31:0] w;
      logic [DW-1:0] d;
      logic [UW-1:0] u;
      logic [SW-1:0] s;
      w = 32'(id) ^ 32'hA5A50000;
      d = {8{w}};
      u = {4{~w}};
      s = last ? 32'h0000FFFF : 32'hFFFFFFFF;
      return {last, u, s, d};
   endfunction

   task automatic push_sb(input logic [SBW-1:0] v, input bit keep);
      sb_in = v;
      sb_in_valid = 1'b1;
      @(posedge clk);
      #1;
      sb_in_valid = 1'b0;
      if (keep) exp_sb.push_back(v);
   endtask

   task automatic send_beat(input beat_t b);
      bit done;
      done = 1'b0;
      {s_tlast, s_tuser, s_tstrb, s_tdata} = b;
      s_tvalid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (s_tready) begin
            exp_beats.push_back(b);
            n_acc++;
            done = 1'b1;
            @(posedge clk);
            #1;
         end
      end
      s_tvalid = 1'b0;
      if (!done) chk("send_timeout", 512'(1'b0), 512'(1'b1));
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 300 && exp_beats.size() != 0; n++) @(negedge clk);
      if (exp_beats.size() != 0) chk("drain_timeout", 512'(exp_beats.size()), 512'(0));
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: check registered outputs against the model, then consume a handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         m_sop = 1'b1; m_sbv = 1'b0; m_sb = '0; m_clr = '0; m_pkt = '0;
         chk("rst_tvalid", 512'(m_tvalid), 512'(1'b0));
      end else begin
         chk("sb_out", 512'(sb_out), 512'(m_sb));
         chk("sb_out_valid", 512'(sb_out_valid), 512'(m_sbv));
         chk("clr_sb_out", 512'(c_sb_out), 512'(m_clr));
         chk("pkt_cnt", 512'(pkt_cnt), 512'(m_pkt));
         chk("twin", 512'({c_tready, c_tvalid, c_tdata, c_tstrb, c_tuser, c_tlast,
                           c_sb_out_valid, c_sb_drop, c_pkt_cnt}),
                     512'({s_tready, m_tvalid, m_tdata, m_tstrb, m_tuser, m_tlast,
                           sb_out_valid, sb_drop, pkt_cnt}));
         if (m_sop && exp_sb.size() == 0) chk("sop_stall", 512'(m_tvalid), 512'(1'b0));
         m_sbv = 1'b0;
         if (m_tvalid && m_tready) begin
            if (exp_beats.size() == 0) begin
               chk("unexpected_beat", 512'(1'b1), 512'(1'b0));
            end else begin
               mon_eb = exp_beats.pop_front();
               chk("beat", 512'({m_tlast, m_tuser, m_tstrb, m_tdata}), 512'(mon_eb));
            end
            if (m_sop) begin
               if (exp_sb.size() == 0) begin
                  chk("unexpected_sop", 512'(1'b1), 512'(1'b0));
               end else begin
                  mon_sb = exp_sb.pop_front();
                  m_sb = mon_sb; m_clr = mon_sb; m_sbv = 1'b1;
               end
               if (!m_tlast) m_sop = 1'b0;
            end else if (m_tlast) begin
               m_sop = 1'b1;
               m_clr = '0;
            end
            if (m_tlast) m_pkt = m_pkt + 32'd1;
         end
      end
   end

   initial begin
      beat_t b;
      int n0;
      s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      sb_in = '0; sb_in_valid = 1'b0; m_tready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_tready", 512'(s_tready), 512'(1'b0));
      chk("rst_m_tvalid", 512'(m_tvalid), 512'(1'b0));
      chk("rst_sb_out", 512'(sb_out), 512'(0));
      chk("rst_sb_valid", 512'(sb_out_valid), 512'(1'b0));
      chk("rst_drop", 512'(sb_drop), 512'(0));
      chk("rst_pkt", 512'(pkt_cnt), 512'(0));
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 3-beat packet, sideband one cycle ahead
      push_sb(64'h0000BEEF_0000CAFE, 1'b1);
      b = mk_beat(1, 1'b0);
      send_beat(b);
      chk("t1_fallthrough", 512'({m_tvalid, m_tdata}), 512'({1'b1, b[DW-1:0]}));
      send_beat(mk_beat(2, 1'b0));
      send_beat(mk_beat(3, 1'b1));
      wait_drain();
      chk("t1_pkt", 512'(pkt_cnt), 512'(32'd1));
      chk("t1_sb", 512'(sb_out), 512'(64'h0000BEEF_0000CAFE));

      // Sideband arrives 5 cycles after the first beat
      send_beat(mk_beat(10, 1'b0));
      chk("t2_wait", 512'(m_tvalid), 512'(1'b0));
      send_beat(mk_beat(11, 1'b0));
      chk("t2_wait", 512'(m_tvalid), 512'(1'b0));
      send_beat(mk_beat(12, 1'b1));
      chk("t2_wait", 512'(m_tvalid), 512'(1'b0));
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("t2_wait", 512'(m_tvalid), 512'(1'b0));
      end
      push_sb(64'h11112222_33334444, 1'b1);
      wait_drain();
      chk("t2_pkt", 512'(pkt_cnt), 512'(32'd2));

      // Fill metadata to depth 4, fifth push dropped, then four 1-beat packets
      m_tready = 1'b0;
      push_sb(64'hAAAA0000_0000000A, 1'b1);
      push_sb(64'hBBBB0000_0000000B, 1'b1);
      push_sb(64'hCCCC0000_0000000C, 1'b1);
      push_sb(64'hDDDD0000_0000000D, 1'b1);
      push_sb(64'hEEEE0000_0000000E, 1'b0);
      chk("t3_drop", 512'(sb_drop), 512'(16'd1));
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(mk_beat(20 + i, 1'b1));
      wait_drain();
      chk("t3_drop_end", 512'(sb_drop), 512'(16'd1));
      chk("t3_last_sb", 512'(sb_out), 512'(64'hDDDD0000_0000000D));

      // Downstream stall for 20 cycles during continuous input
      m_tready = 1'b0;
      push_sb(64'h44440000_00004444, 1'b1);
      n0 = n_acc;
      fork
         begin
            for (int i = 0; i < 12; i++) send_beat(mk_beat(30 + i, (i == 11)));
         end
         begin
            repeat (20) @(posedge clk);
            #1;
            chk("t4_accepted", 512'(n_acc - n0), 512'(7));
            chk("t4_s_tready", 512'(s_tready), 512'(1'b0));
            m_tready = 1'b1;
         end
      join
      wait_drain();

      // Two-beat packet: cleared copy returns to zero after EOP
      push_sb(64'h00005A5A_0000A5A5, 1'b1);
      send_beat(mk_beat(50, 1'b0));
      send_beat(mk_beat(51, 1'b1));
      wait_drain();
      chk("t5_clr", 512'(c_sb_out), 512'(0));
      chk("t5_hold", 512'(sb_out), 512'(64'h00005A5A_0000A5A5));

      // Asynchronous reset mid-packet
      m_tready = 1'b0;
      push_sb(64'hDEADDEAD_DEADDEAD, 1'b1);
      send_beat(mk_beat(60, 1'b0));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_s_tready", 512'(s_tready), 512'(1'b0));
      chk("t6_m_tvalid", 512'(m_tvalid), 512'(1'b0));
      chk("t6_sb_out", 512'(sb_out), 512'(0));
      chk("t6_drop", 512'(sb_drop), 512'(0));
      chk("t6_pkt", 512'(pkt_cnt), 512'(0));
      exp_beats.delete();
      exp_sb.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      m_tready = 1'b1;
      push_sb(64'h00000001_00000002, 1'b1);
      send_beat(mk_beat(70, 1'b0));
      send_beat(mk_beat(71, 1'b1));
      wait_drain();
      chk("t6_pkt_after", 512'(pkt_cnt), 512'(32'd1));
      chk("t6_sb_after", 512'(sb_out), 512'(64'h00000001_00000002));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sideband_align_fifo.md
Name: sideband_align_fifo

Overview:
- Parametrised successor to the single-checksum output-port-lookup alignment stage.
- Buffers an AXI4-Stream packet path in a fall-through data FIFO.
- Queues per-packet sideband words (checksums, lookup results) in a metadata FIFO and releases exactly one entry per packet, aligned to that packet's first output beat.
- Multiple packets may be in flight; output stalls at start-of-packet (SOP) until its sideband entry exists.

Parameters:
- C_AXIS_DATA_WIDTH, 256, TDATA width in bits; TSTRB width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, TUSER width.
- NUM_WORDS, 2, number of 32-bit sideband words per packet.
- DATA_DEPTH_BITS, 3, data FIFO depth is 2**DATA_DEPTH_BITS beats.
- META_DEPTH_BITS, 2, metadata FIFO depth is 2**META_DEPTH_BITS entries.
- CLEAR_ON_EOP, 0, 1 zeroes SB_OUT after the EOP handshake; 0 holds it until the next SOP.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_RESETN  in  1  asynchronous active-low reset.
- S_AXIS_TDATA / TSTRB / TUSER / TVALID / TLAST  in  per parameters  upstream stream.
- S_AXIS_TREADY  out  1  upstream ready.
- M_AXIS_TDATA / TSTRB / TUSER / TVALID / TLAST  out  per parameters  downstream stream.
- M_AXIS_TREADY  in  1  downstream ready.
- SB_IN  in  NUM_WORDS*32  sideband words for the next packet; word 0 in bits [31:0].
- SB_IN_VALID  in  1  single-cycle push strobe.
- SB_OUT  out  NUM_WORDS*32  registered sideband of the current output packet.
- SB_OUT_VALID  out  1  one-cycle pulse when SB_OUT updates.
- SB_DROP_CNT  out  16  saturating count of sideband pushes lost to a full metadata FIFO.
- PKT_CNT  out  32  wrapping count of packets completed at the output (EOP handshakes).

Behaviour:
- Reset is asynchronous on AXI_RESETN low. While low, all of the following hold:
  - Both FIFOs are emptied.
  - The state machine is in SOP.
  - S_AXIS_TREADY=0 and M_AXIS_TVALID=0.
  - SB_OUT=0, SB_OUT_VALID=0, SB_DROP_CNT=0, PKT_CNT=0.
- Reset mid-packet discards all buffered beats and metadata. There is no partial-packet recovery.
- Data FIFO:
  - Fall-through. A beat accepted at edge t is visible on M_AXIS at t+1.
  - S_AXIS_TREADY = !data_nearly_full, where nearly_full means at most one free slot.
  - A write occurs on S_AXIS_TVALID & S_AXIS_TREADY.
- Metadata FIFO:
  - Push on SB_IN_VALID when not full.
  - Push while full and a pop occurs in the same cycle: the push is accepted.
  - Push while full with no pop: the entry is dropped and SB_DROP_CNT increments, saturating at 16'hFFFF.
- State machine:
  - SOP state: M_AXIS_TVALID = !data_empty & !meta_empty.
  - BODY state: M_AXIS_TVALID = !data_empty.
  - A handshake is M_AXIS_TVALID & M_AXIS_TREADY.
  - Handshake in SOP: pop metadata; SB_OUT <= popped entry; SB_OUT_VALID=1 next cycle. If TLAST=0, go to BODY; if TLAST=1 (single-beat packet), stay in SOP.
  - Handshake with TLAST in BODY: go to SOP.
  - Every TLAST handshake increments PKT_CNT (wraps).
  - CLEAR_ON_EOP=1: SB_OUT <= 0 on the TLAST handshake, except a single-beat packet, where the SOP load takes priority.
- Timing:
  - SB_OUT is valid from the cycle after the SOP handshake.
  - Upstream must assert SB_IN_VALID no later than the edge at which that packet's first beat reaches the data FIFO head. If it is later, the output waits without data loss.
- The data FIFO never waits on the metadata FIFO for writes. Backpressure to upstream comes only from the data FIFO.
- Ordering: the nth metadata entry belongs to the nth packet. The block does not resynchronise after a drop; SB_DROP_CNT flags the misalignment.
- All outputs are registered except the M_AXIS fall-through path and S_AXIS_TREADY.

Decomposition:
- Shared package:
  - SB_WORD_WIDTH=32.
  - State encoding ST_SOP=1'b0, ST_BODY=1'b1.
  - Sideband vector width function NUM_WORDS*SB_WORD_WIDTH.
- Sub-module: one generic fall-through FIFO, instantiated twice.
  - Data FIFO width: DATA+TUSER+DATA/8+1.
  - Metadata FIFO width: NUM_WORDS*32.
- The state machine and counters live in the top.

Test Plan:
- Single 3-beat packet, SB_IN={32'h0000BEEF,32'h0000CAFE} pushed 1 cycle before first beat, TREADY=1 -> M_AXIS beats 1 cycle after input, SB_OUT=that value with SB_OUT_VALID pulse the cycle after beat 0, PKT_CNT=1.
- Packet with metadata pushed 5 cycles after its first beat -> M_AXIS_TVALID stays 0 for those cycles, then the packet streams with correct SB_OUT, no beat lost.
- Four back-to-back 1-beat packets with sideband A,B,C,D, then META depth 4 plus a fifth push with no pop -> SB_OUT sequence A,B,C,D, SB_DROP_CNT=1.
- M_AXIS_TREADY=0 for 20 cycles during continuous input -> S_AXIS_TREADY falls with at most one free slot; after release, all beats appear in order with data intact.
- CLEAR_ON_EOP=1, 2-beat packet -> SB_OUT=value after SOP, returns to 0 the cycle after the TLAST handshake.
- Assert AXI_RESETN low mid-packet, asynchronously between edges -> outputs 0 immediately, FIFOs empty; next packet with fresh sideband passes correctly.
